// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction-memory, redirect and decode-side signals of the fetch stage
interface fetch_queue_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) ();
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - sequential instruction fetch with DEPTH-entry queue and redirect flush
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushes counters.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  fetch_queue_unit_if.master  bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stat_fetched,
  output logic [31:0]         stat_flushes
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  logic               redirect;
  logic               not_empty;
  logic [CNT_W:0]     occupancy;
  logic               issue;
  logic               push;
  logic               pop;

  assign redirect  = bus.redirect_valid;
  assign not_empty = (count_q != '0);

  // Credit: a request is only issued if its response is guaranteed a free slot.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue     = !reset && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = inflight_q && !redirect;
  assign pop       = not_empty && bus.out_ready && !redirect;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = not_empty;
  assign bus.out_instr = not_empty ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.out_pc    = not_empty ? pc_mem_q[rd_ptr_q]    : '0;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect) begin
      pc_d     = bus.redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + ADDR_W'(PC_STEP);
        inflight_pc_d = pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushes_q, stat_flushes_d;

  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(pop);
    stat_flushes_d = stat_flushes_q + 32'(redirect);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed-vector bench for fetch_queue_unit
module tb_fetch_queue_unit;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushes;
`endif

  fetch_queue_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushes(stat_flushes)
`endif
  );

  // mem[i] = i, one-cycle read latency
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr >> 2;
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          n_req = 0;
  logic [31:0] exp_pc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples the current cycle (scoreboarding every accepted entry), then moves to the next negedge.
  task automatic tick();
    #1;
    if (!reset && bus.imem_req) n_req++;
    if (!reset && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      check("pop_pc", bus.out_pc, exp_pc);
      check("pop_instr", bus.out_instr, exp_pc >> 2);
      exp_pc = exp_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
`ifdef FETCH_STATS_EN
    check("rst_stat_fetched", stat_fetched, 0);
    check("rst_stat_flushes", stat_flushes, 0);
`endif

    // Streaming from reset
    @(negedge clk);
    reset = 1'b0; bus.out_ready = 1'b1; exp_pc = 32'h0;
    #1;
    check("t1_req0", bus.imem_req, 1);
    check("t1_addr0", bus.imem_addr, 32'h0);
    check("t1_valid0", bus.out_valid, 0);
    tick();
    #1;
    check("t1_addr1", bus.imem_addr, 32'h4);
    check("t1_valid1", bus.out_valid, 0);
    tick();
    for (int k = 2; k < 10; k++) begin
      #1;
      check("t1_addr", bus.imem_addr, 32'(4 * k));
      check("t1_valid", bus.out_valid, 1);
      check("t1_out_pc", bus.out_pc, 32'(4 * (k - 2)));
      tick();
    end

    // Reset mid-stream
    reset = 1'b1;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_req", bus.imem_req, 0);
    check("t6_rst_out_pc", bus.out_pc, 0);
    @(negedge clk); @(negedge clk);

    // Backpressure: only DEPTH requests while stalled
    reset = 1'b0; bus.out_ready = 1'b0; exp_pc = 32'h0; n_req = 0;
    repeat (10) tick();
    check("t2_nreq", n_req, DEPTH);
    #1;
    check("t2_full_req", bus.imem_req, 0);
    check("t2_full_valid", bus.out_valid, 1);
    check("t2_head_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    #1;
    check("t2_release_req", bus.imem_req, 0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_drain_valid", bus.out_valid, 1);
      tick();
    end

    // Push and pop at count=DEPTH-1
    bus.out_ready = 1'b0;
    #1;
    check("t4_stall_req", bus.imem_req, 1);
    tick();
    bus.out_ready = 1'b1;
    #1;
    check("t4_credit_req", bus.imem_req, 0);
    check("t4_valid_a", bus.out_valid, 1);
    tick();
    #1;
    check("t4_req_b", bus.imem_req, 1);
    check("t4_valid_b", bus.out_valid, 1);
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t4_valid", bus.out_valid, 1);
      tick();
    end

    // Redirect with 3 queued + 1 in flight, pop in redirect cycle ignored
    bus.out_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; bus.out_ready = 1'b1;
    #1;
    check("t3_redir_req", bus.imem_req, 0);
    tick();
    bus.redirect_valid = 1'b0; exp_pc = 32'h100;
    #1;
    check("t3_valid0", bus.out_valid, 0);
    check("t3_req0", bus.imem_req, 1);
    check("t3_addr0", bus.imem_addr, 32'h100);
    tick();
    #1;
    check("t3_valid1", bus.out_valid, 0);
    check("t3_addr1", bus.imem_addr, 32'h104);
    tick();
    #1;
    check("t3_valid2", bus.out_valid, 1);
    check("t3_out_pc", bus.out_pc, 32'h100);
    check("t3_out_instr", bus.out_instr, 32'h40);
    repeat (4) tick();

    // Back-to-back redirects: last wins
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect_valid = 1'b0; exp_pc = 32'h300;
    #1;
    check("t3b_addr", bus.imem_addr, 32'h300);
    check("t3b_valid", bus.out_valid, 0);
    tick();
    tick();
    #1;
    check("t3b_valid2", bus.out_valid, 1);
    check("t3b_out_pc", bus.out_pc, 32'h300);
    repeat (3) tick();

    // Address wrap
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0; exp_pc = 32'hFFFF_FFF8;
    #1;
    check("t5_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    tick();
    #1;
    check("t5_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    #1;
    check("t5_wrap", bus.imem_addr, 32'h0);
    check("t5_out_pc", bus.out_pc, 32'hFFFF_FFF8);
    repeat (4) tick();

    // Statistics: 5 pops + 2 redirects after a fresh reset
    reset = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; exp_pc = 32'h0;
    repeat (6) tick();
    bus.out_ready = 1'b1;
    repeat (5) tick();
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    repeat (2) tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t6_flush_valid", bus.out_valid, 0);
    check("t6_flush_addr", bus.imem_addr, 32'h40);
`ifdef FETCH_STATS_EN
    check("stat_fetched", stat_fetched, 5);
    check("stat_flushes", stat_flushes, 2);
    reset = 1'b1;
    #1;
    check("stat_fetched_rst", stat_fetched, 0);
    check("stat_flushes_rst", stat_flushes, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
